spi2adc_scan: RTL

- Parametrised SPI master for MCP3xxx-family successive-approximation ADCs (MCP3002/3202/3004/3008 class). Covers any data width, channel count and SCK rate.
- Supports single-shot conversions on a `start` pulse, or continuous round-robin scanning of all channels.
- Delivers each result with its channel tag as a one-cycle `data_valid` pulse.
- Sits between the audio sampling/processing pipeline and the off-chip ADC pins.

---
 rtl/spi2adc_scan_if.sv | 45 ++++
 rtl/spi2adc_scan.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi2adc_scan_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi2adc_scan_if
//  Purpose  : Bundles the request/result handshake and the ADC pin-level SPI
//             signals of spi2adc_scan into one interface.
//  Ports    : start/channel/scan_en/clr_ovr   - conversion requests
//             data_from_adc/data_ch/data_valid - result delivery
//             busy/overrun                     - status
//             sdata_to_adc/adc_cs/adc_sck      - SPI pins driven to the ADC
//             sdata_from_adc                   - SPI DOUT returned by the ADC
//  Modports : slave  - the converter core (spi2adc_scan)
//             master - the surrounding system (requester and ADC pins)
//  Revision : 1.0 - initial release
// ============================================================================
interface spi2adc_scan_if #(
  parameter int unsigned DATA_W  = 10,
  parameter int unsigned CH_BITS = 1
);
  logic                start;
  logic [CH_BITS-1:0]  channel;
  logic                scan_en;
  logic                clr_ovr;
  logic [DATA_W-1:0]   data_from_adc;
  logic [CH_BITS-1:0]  data_ch;
  logic                data_valid;
  logic                busy;
  logic                overrun;
  logic                sdata_to_adc;
  logic                adc_cs;
  logic                adc_sck;
  logic                sdata_from_adc;

  modport slave (
    input  start, channel, scan_en, clr_ovr, sdata_from_adc,
    output data_from_adc, data_ch, data_valid, busy, overrun,
           sdata_to_adc, adc_cs, adc_sck
  );

  modport master (
    output start, channel, scan_en, clr_ovr, sdata_from_adc,
    input  data_from_adc, data_ch, data_valid, busy, overrun,
           sdata_to_adc, adc_cs, adc_sck
  );
endinterface
`default_nettype wire

// File: rtl/spi2adc_scan.sv
`default_nettype none
// ============================================================================
//  Module   : spi2adc_scan
//  Purpose  : SPI master for MCP3xxx-class SAR ADCs. Runs single-shot
//             conversions on a start edge or continuous round-robin scans,
//             and returns each result tagged with its channel.
//  Ports    : sysclk - system clock
//             reset  - asynchronous active-high reset
//             bus    - spi2adc_scan_if.slave (requests, results, status,
//                      SPI pins sdata_to_adc/adc_cs/adc_sck/sdata_from_adc)
//  Revision : 1.0 - initial release
// ============================================================================
module spi2adc_scan #(
  parameter int unsigned CLK_DIV  = 25,
  parameter int unsigned DATA_W   = 10,
  parameter int unsigned CH_BITS  = 1,
  parameter logic        SGL      = 1'b1,
  parameter int unsigned TAIL_BIT = 1
) (
  input  logic         sysclk,
  input  logic         reset,
  spi2adc_scan_if.slave bus
);

  localparam int unsigned CMD_W = 2 + CH_BITS + TAIL_BIT;
  localparam int unsigned N_SCK = CMD_W + 1 + DATA_W;
  localparam int unsigned HC_W  = $clog2(2 * N_SCK);

  localparam logic [7:0]      DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [HC_W-1:0] HC_LAST  = HC_W'(2 * N_SCK - 1);
  // High phase of the first data bit (after command bits and the null bit).
  localparam logic [HC_W-1:0] HC_FIRST_DATA = HC_W'(2 * (CMD_W + 1) + 1);
  localparam logic [HC_W-1:0] HC_ONE        = HC_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    GUARD = 2'd2
  } state_t;

  state_t              state_q;
  logic [7:0]          div_cnt_q;   // sysclk cycles within an SCK half-period
  logic [HC_W-1:0]     hcnt_q;      // SCK half-period index (also guard timer)
  logic                sck_q;
  logic                cs_q;
  logic                sdo_q;
  logic [CMD_W-1:0]    cmd_sr_q;    // command bits still to be shifted out
  logic [DATA_W-1:0]   shift_q;
  logic [DATA_W-1:0]   data_q;
  logic [CH_BITS-1:0]  data_ch_q;
  logic                valid_q;
  logic                busy_q;
  logic                ovr_q;
  logic                start_prev_q;
  logic                pend_q;
  logic [CH_BITS-1:0]  pend_ch_q;
  logic [CH_BITS-1:0]  ptr_q;
  logic [CH_BITS-1:0]  cur_ch_q;
  logic                scan_frame_q;

  logic                start_rise;
  logic                frame_done;
  logic                guard_end;
  logic                acc_win;
  logic                acc_scan;
  logic                acc_single;
  logic                accept;
  logic                capture;
  logic                drop;
  logic [CH_BITS-1:0]  acc_ch;
  logic [CMD_W-1:0]    cmd_w;

  assign start_rise = bus.start & ~start_prev_q;
  assign frame_done = (state_q == FRAME) && (hcnt_q == HC_LAST) && (div_cnt_q == DIV_LAST);
  assign guard_end  = (state_q == GUARD) && (hcnt_q == HC_ONE) && (div_cnt_q == DIV_LAST);

  // A new frame may start from IDLE or directly in the last guard cycle, so
  // back-to-back frames stay separated by exactly the guard interval.
  assign acc_win    = (state_q == IDLE) || guard_end;
  assign acc_scan   = acc_win & bus.scan_en;
  assign acc_single = acc_win & ~bus.scan_en & (start_rise | pend_q);
  assign accept     = acc_scan | acc_single;

  // An older pending request is served before a start edge seen this cycle.
  assign acc_ch = bus.scan_en ? ptr_q : (pend_q ? pend_ch_q : bus.channel);

  // Start edges while scanning are ignored. Otherwise an edge is captured as
  // pending when the pending slot is (or becomes) free, and dropped if full.
  assign capture = ~bus.scan_en & start_rise & (acc_win ? pend_q : ~pend_q);
  assign drop    = ~bus.scan_en & start_rise & ~acc_win & pend_q;

  // Command word, bit 0 shifted first: start, SGL, channel MSB-first, tail.
  assign cmd_w[0] = 1'b1;
  assign cmd_w[1] = SGL;
  for (genvar i = 0; i < CH_BITS; i++) begin : g_cmd_ch
    assign cmd_w[2+i] = acc_ch[CH_BITS-1-i];
  end
  if (TAIL_BIT != 0) begin : g_tail
    assign cmd_w[CMD_W-1] = 1'b1;
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      div_cnt_q    <= '0;
      hcnt_q       <= '0;
      sck_q        <= 1'b0;
      cs_q         <= 1'b1;
      sdo_q        <= 1'b0;
      cmd_sr_q     <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      data_ch_q    <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      ovr_q        <= 1'b0;
      start_prev_q <= 1'b0;
      pend_q       <= 1'b0;
      pend_ch_q    <= '0;
      ptr_q        <= '0;
      cur_ch_q     <= '0;
      scan_frame_q <= 1'b0;
    end else begin
      start_prev_q <= bus.start;
      valid_q      <= 1'b0;

      if (capture) begin
        pend_q    <= 1'b1;
        pend_ch_q <= bus.channel;
      end else if (acc_single) begin
        pend_q <= 1'b0;
      end

      // Setting wins over a simultaneous clear.
      if (drop) begin
        ovr_q <= 1'b1;
      end else if (bus.clr_ovr) begin
        ovr_q <= 1'b0;
      end

      // Pointer sits at 0 whenever scanning is off, so a scan that stopped
      // mid-frame restarts from channel 0 once that frame has finished.
      if (!bus.scan_en) begin
        ptr_q <= '0;
      end else if (frame_done && scan_frame_q) begin
        ptr_q <= ptr_q + CH_BITS'(1);
      end

      if (accept) begin
        state_q      <= FRAME;
        cs_q         <= 1'b0;
        busy_q       <= 1'b1;
        sck_q        <= 1'b0;
        div_cnt_q    <= '0;
        hcnt_q       <= '0;
        sdo_q        <= cmd_w[0];
        cmd_sr_q     <= cmd_w >> 1;
        cur_ch_q     <= acc_ch;
        scan_frame_q <= acc_scan;
      end else begin
        case (state_q)
          IDLE: begin
            busy_q <= 1'b0;
          end

          FRAME: begin
            // DOUT is sampled in the first sysclk cycle of each SCK high
            // phase, skipping the command and null bits.
            if (sck_q && (div_cnt_q == 8'd0) && (hcnt_q >= HC_FIRST_DATA)) begin
              shift_q <= {shift_q[DATA_W-2:0], bus.sdata_from_adc};
            end
            if (div_cnt_q == DIV_LAST) begin
              div_cnt_q <= '0;
              if (frame_done) begin
                state_q   <= GUARD;
                hcnt_q    <= '0;
                sck_q     <= 1'b0;
                cs_q      <= 1'b1;
                sdo_q     <= 1'b0;
                data_q    <= shift_q;
                data_ch_q <= cur_ch_q;
                valid_q   <= 1'b1;
              end else begin
                hcnt_q <= hcnt_q + HC_ONE;
                sck_q  <= ~sck_q;
                // DIN only moves on the SCK falling edge.
                if (sck_q) begin
                  sdo_q    <= cmd_sr_q[0];
                  cmd_sr_q <= {1'b0, cmd_sr_q[CMD_W-1:1]};
                end
              end
            end else begin
              div_cnt_q <= div_cnt_q + 8'd1;
            end
          end

          GUARD: begin
            if (guard_end) begin
              state_q   <= IDLE;
              busy_q    <= 1'b0;
              div_cnt_q <= '0;
              hcnt_q    <= '0;
            end else if (div_cnt_q == DIV_LAST) begin
              div_cnt_q <= '0;
              hcnt_q    <= hcnt_q + HC_ONE;
            end else begin
              div_cnt_q <= div_cnt_q + 8'd1;
            end
          end

          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.sdata_to_adc  = sdo_q;
  assign bus.adc_cs        = cs_q;
  assign bus.adc_sck       = sck_q;
  assign bus.data_from_adc = data_q;
  assign bus.data_ch       = data_ch_q;
  assign bus.data_valid    = valid_q;
  assign bus.busy          = busy_q;
  assign bus.overrun       = ovr_q;

endmodule
`default_nettype wire
